psram_ddr_ctrl: RTL and testbench

Single-clock command/timing engine for an x16 HyperBus-style DDR PSRAM (W958D6NK class).
- After reset it waits for device power-up, then writes configuration register CR0.
- It then serves burst read/write requests from a user port.
- Each ram_clk cycle carries one 32-bit word as hi/lo 16-bit halves to and from an external DDR PHY, which generates the device clock, CE and DQ/RWDS pads.

---
 rtl/psram_ddr_ctrl_if.sv | 39 +++
 rtl/psram_ddr_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_psram_ddr_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_ddr_ctrl_if.sv
// psram_ddr_ctrl_if: user request port plus DDR PHY pins of the PSRAM controller.
// slave = controller side, master = user/PHY side.
interface psram_ddr_ctrl_if;
    logic        ram_en;
    logic        rw_ctrl;
    logic [31:0] addr_in;
    logic [31:0] ram_data_in;
    logic        init_cable_complete;
    logic        ctrl_idle;
    logic        psram_clk;
    logic        psram_ce;
    logic        dq_en;
    logic [15:0] dq_out_hi;
    logic [15:0] dq_out_lo;
    logic [15:0] dq_in_hi;
    logic [15:0] dq_in_lo;
    logic        dm_en;
    logic [1:0]  dm_out_hi;
    logic [1:0]  dm_out_lo;
    logic [1:0]  dm_in_hi;
    logic [1:0]  dm_in_lo;
    logic [31:0] ram_data_out;
    logic        ram_rd_valid;
    logic        ram_wr_valid;

    modport slave (
        input  ram_en, rw_ctrl, addr_in, ram_data_in, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo,
        output init_cable_complete, ctrl_idle, psram_clk, psram_ce, dq_en, dq_out_hi,
               dq_out_lo, dm_en, dm_out_hi, dm_out_lo, ram_data_out, ram_rd_valid,
               ram_wr_valid
    );

    modport master (
        output ram_en, rw_ctrl, addr_in, ram_data_in, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo,
        input  init_cable_complete, ctrl_idle, psram_clk, psram_ce, dq_en, dq_out_hi,
               dq_out_lo, dm_en, dm_out_hi, dm_out_lo, ram_data_out, ram_rd_valid,
               ram_wr_valid
    );
endinterface

// File: rtl/psram_ddr_ctrl.sv
// psram_ddr_ctrl: command/timing engine for an x16 HyperBus-style DDR PSRAM.
// Power-up wait, CR0 write, then burst reads/writes; one 32-bit word per ram_clk.
// Optional macro PSRAM_RD_TIMEOUT_EN: abort a read after 64 cycles without an RWDS word.
module psram_ddr_ctrl #(
    parameter int    PSRAM_FRE = 200_000_000,
    parameter int    INIT_US   = 150,
    parameter int    LATENCY   = 7,
    parameter int    BIT_WIDTH = 16,
    parameter int    BURST_LEN = 16,
    parameter string WRAP_MODE = "Wrap",
    parameter string RW_METHOD = "Linear"
) (
    input logic             ram_clk,
    input logic             ram_rst,
    psram_ddr_ctrl_if.slave bus
);

    localparam int INIT_CYCLES = PSRAM_FRE / 1_000_000 * INIT_US;
    localparam int LAT_CYCLES  = 2 * LATENCY;

    localparam logic [3:0] LAT_CODE = (LATENCY == 3) ? 4'b1110 :
                                      (LATENCY == 4) ? 4'b1111 :
                                      (LATENCY == 5) ? 4'b0000 :
                                      (LATENCY == 6) ? 4'b0001 : 4'b0010;
    localparam logic [1:0] BURST_CODE = (BURST_LEN == 4)  ? 2'b10 :
                                        (BURST_LEN == 8)  ? 2'b11 :
                                        (BURST_LEN == 16) ? 2'b01 : 2'b00;
    localparam logic WRAP_BIT   = (WRAP_MODE == "Wrap");
    localparam logic LINEAR_BIT = (RW_METHOD == "Linear");

    localparam logic [15:0] CR0    = {1'b1, 3'b000, 4'b1111, LAT_CODE, 1'b1, WRAP_BIT, BURST_CODE};
    localparam logic [47:0] CFG_CA = 48'h6000_0001_0000;

    typedef enum logic [3:0] {
        INIT_WAIT, CFG_CA1, CFG_CA2, CFG_DATA, RECOVER, IDLE, CA1, CA2, LAT, WRITE, READ
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [5:0]  word_cnt;
    logic        is_write;
    logic [15:0] ca_lo;
    logic        ce_q, clk_en_q, dq_en_q, dm_en_q, idle_q, init_done_q, rd_valid_q;
    logic [15:0] dq_hi_q, dq_lo_q;
    logic [31:0] data_out_q;
`ifdef PSRAM_RD_TIMEOUT_EN
    logic [5:0]  to_cnt;
`endif

    logic [31:0] word_addr;
    logic [47:0] ca_next;
    logic        rd_word;
    logic        unused_sig;

    assign word_addr = {1'b0, bus.addr_in[31:1]};
    assign ca_next   = {~bus.rw_ctrl, 1'b0, LINEAR_BIT, word_addr[31:3], 13'd0, word_addr[2:0]};
    // RWDS high on the rising half and low on the falling half marks a valid word
    assign rd_word   = (bus.dm_in_hi == 2'b11) && (bus.dm_in_lo == 2'b00);
    assign unused_sig = bus.addr_in[0] ^ (BIT_WIDTH != 16);

    // Sequencer: state, counters and registered PHY/user outputs
    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            state       <= INIT_WAIT;
            cnt         <= '0;
            word_cnt    <= '0;
            is_write    <= 1'b0;
            ca_lo       <= '0;
            ce_q        <= 1'b1;
            clk_en_q    <= 1'b0;
            dq_en_q     <= 1'b0;
            dm_en_q     <= 1'b0;
            idle_q      <= 1'b0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            dq_hi_q     <= '0;
            dq_lo_q     <= '0;
            data_out_q  <= '0;
`ifdef PSRAM_RD_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                INIT_WAIT: begin
                    if (cnt == 32'(INIT_CYCLES - 1)) begin
                        cnt      <= '0;
                        state    <= CFG_CA1;
                        ce_q     <= 1'b0;
                        clk_en_q <= 1'b1;
                        dq_en_q  <= 1'b1;
                        dq_hi_q  <= CFG_CA[47:32];
                        dq_lo_q  <= CFG_CA[31:16];
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CFG_CA1: begin
                    state   <= CFG_CA2;
                    dq_hi_q <= CFG_CA[15:0];
                    dq_lo_q <= '0;
                end
                CFG_CA2: begin
                    state   <= CFG_DATA;
                    dq_hi_q <= CR0;
                    dq_lo_q <= '0;
                end
                CFG_DATA: begin
                    state <= RECOVER; cnt <= '0; ce_q <= 1'b1; clk_en_q <= 1'b0;
                    dq_en_q <= 1'b0; dm_en_q <= 1'b0; dq_hi_q <= '0; dq_lo_q <= '0;
                end
                RECOVER: begin
                    if (cnt == 32'd1) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        idle_q      <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (bus.ram_en) begin
                        state    <= CA1;
                        idle_q   <= 1'b0;
                        is_write <= bus.rw_ctrl;
                        ca_lo    <= ca_next[15:0];
                        ce_q     <= 1'b0;
                        clk_en_q <= 1'b1;
                        dq_en_q  <= 1'b1;
                        dq_hi_q  <= ca_next[47:32];
                        dq_lo_q  <= ca_next[31:16];
                    end
                end
                CA1: begin
                    state   <= CA2;
                    dq_hi_q <= ca_lo;
                    dq_lo_q <= '0;
                end
                CA2: begin
                    state   <= LAT;
                    cnt     <= '0;
                    dq_en_q <= 1'b0;
                    dq_hi_q <= '0;
                end
                LAT: begin
                    if (cnt == 32'(LAT_CYCLES - 1)) begin
                        cnt      <= '0;
                        word_cnt <= '0;
`ifdef PSRAM_RD_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        if (is_write) begin
                            state   <= WRITE;
                            dq_en_q <= 1'b1;
                            dm_en_q <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WRITE: begin
                    if (word_cnt == 6'(BURST_LEN - 1)) begin
                        state <= RECOVER; cnt <= '0; ce_q <= 1'b1; clk_en_q <= 1'b0;
                        dq_en_q <= 1'b0; dm_en_q <= 1'b0; dq_hi_q <= '0; dq_lo_q <= '0;
                    end else begin
                        word_cnt <= word_cnt + 6'd1;
                    end
                end
                READ: begin
                    if (rd_word) begin
                        data_out_q <= {bus.dq_in_hi, bus.dq_in_lo};
                        rd_valid_q <= 1'b1;
`ifdef PSRAM_RD_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        if (word_cnt == 6'(BURST_LEN - 1)) begin
                            state <= RECOVER; cnt <= '0; ce_q <= 1'b1; clk_en_q <= 1'b0;
                            dq_en_q <= 1'b0; dm_en_q <= 1'b0; dq_hi_q <= '0; dq_lo_q <= '0;
                        end else begin
                            word_cnt <= word_cnt + 6'd1;
                        end
                    end
`ifdef PSRAM_RD_TIMEOUT_EN
                    else if (to_cnt == 6'd63) begin
                        state <= RECOVER; cnt <= '0; ce_q <= 1'b1; clk_en_q <= 1'b0;
                        dq_en_q <= 1'b0; dm_en_q <= 1'b0; dq_hi_q <= '0; dq_lo_q <= '0;
                    end else begin
                        to_cnt <= to_cnt + 6'd1;
                    end
`else
                    // without the timeout a stalled device holds READ indefinitely
`endif
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

    // Write data bypasses the registers so the word is on DQ in the cycle it is consumed
    assign bus.ram_wr_valid        = (state == WRITE);
    assign bus.dq_out_hi           = (state == WRITE) ? bus.ram_data_in[31:16] : dq_hi_q;
    assign bus.dq_out_lo           = (state == WRITE) ? bus.ram_data_in[15:0] : dq_lo_q;
    assign bus.dm_out_hi           = 2'b00;
    assign bus.dm_out_lo           = 2'b00;
    assign bus.psram_ce            = ce_q;
    assign bus.psram_clk           = clk_en_q;
    assign bus.dq_en               = dq_en_q;
    assign bus.dm_en               = dm_en_q;
    assign bus.ctrl_idle           = idle_q;
    assign bus.init_cable_complete = init_done_q;
    assign bus.ram_rd_valid        = rd_valid_q;
    assign bus.ram_data_out        = data_out_q;

endmodule

// File: tb/tb_psram_ddr_ctrl.sv
// tb_psram_ddr_ctrl: directed bench with a cycle-level expectation queue built from the
// protocol rules, plus a PHY/RWDS model and a few literal spot checks.
module tb_psram_ddr_ctrl;
    localparam int LATENCY   = 7;
    localparam int BURST_LEN = 16;
    localparam int INIT_CYC  = 200;
    localparam logic [47:0] CFG_CA = 48'h6000_0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psram_ddr_ctrl_if bus();

    psram_ddr_ctrl #(
        .PSRAM_FRE(200_000_000), .INIT_US(1), .LATENCY(LATENCY), .BIT_WIDTH(16),
        .BURST_LEN(BURST_LEN), .WRAP_MODE("Wrap"), .RW_METHOD("Linear")
    ) dut (
        .ram_clk(clk),
        .ram_rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        ce, ck, dq_en, dm_en, idle, init, wrv, rdv;
        logic [15:0] hi, lo;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_data = '0;
    logic        model_init = 1'b0;
    logic [31:0] mem [BURST_LEN];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command address from the field rules, built arithmetically
    function automatic logic [47:0] model_ca(input logic [31:0] addr, input logic rd);
        logic [47:0] w;
        w = {16'd0, addr} >> 1;
        return ({47'd0, rd} << 47) | (48'd1 << 45) | ((w >> 3) << 16) | (w & 48'd7);
    endfunction

    function automatic logic [15:0] model_cr0();
        logic [3:0] lc;
        logic [1:0] bc;
        case (LATENCY)
            3: lc = 4'b1110;
            4: lc = 4'b1111;
            5: lc = 4'b0000;
            6: lc = 4'b0001;
            default: lc = 4'b0010;
        endcase
        case (BURST_LEN)
            4: bc = 2'b10;
            8: bc = 2'b11;
            16: bc = 2'b01;
            default: bc = 2'b00;
        endcase
        return 16'h8000 | 16'h0F00 | (16'(lc) << 4) | 16'h0008 | 16'h0004 | 16'(bc);
    endfunction

    function automatic exp_t rec_off(input logic idle);
        exp_t e;
        e = '0;
        e.ce = 1'b1;
        e.idle = idle;
        e.init = model_init;
        return e;
    endfunction

    function automatic exp_t rec_bus(input logic [15:0] hi, input logic [15:0] lo,
                                     input logic dq_en, input logic dm_en, input logic wrv);
        exp_t e;
        e = '0;
        e.ck = 1'b1;
        e.dq_en = dq_en;
        e.dm_en = dm_en;
        e.wrv = wrv;
        e.hi = hi;
        e.lo = lo;
        e.init = model_init;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_cycle(input exp_t e);
        e.rdv = pend_rd;
        e.rdata = pend_data;
        pend_rd = 1'b0;
        q.push_back(e);
    endtask

    // Compare DUT outputs with the expectation for the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("psram_ce", bus.psram_ce, e.ce);
            chk("psram_clk", bus.psram_clk, e.ck);
            chk("dq_en", bus.dq_en, e.dq_en);
            chk("dm_en", bus.dm_en, e.dm_en);
            chk("ctrl_idle", bus.ctrl_idle, e.idle);
            chk("init_cable_complete", bus.init_cable_complete, e.init);
            chk("ram_wr_valid", bus.ram_wr_valid, e.wrv);
            chk("ram_rd_valid", bus.ram_rd_valid, e.rdv);
            if (e.dq_en) begin
                chk("dq_out_hi", bus.dq_out_hi, e.hi);
                chk("dq_out_lo", bus.dq_out_lo, e.lo);
            end
            if (e.dm_en) begin
                chk("dm_out_hi", bus.dm_out_hi, 2'b00);
                chk("dm_out_lo", bus.dm_out_lo, 2'b00);
            end
            if (e.rdv) chk("ram_data_out", bus.ram_data_out, e.rdata);
        end
    end

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            rst = 1'b1;
            bus.ram_en = 1'b0;
            bus.dm_in_hi = 2'b00;
            bus.dm_in_lo = 2'b00;
            pend_rd = 1'b0;
            model_init = 1'b0;
            expect_cycle(rec_off(1'b0));
        end
    endtask

    task automatic init_seq();
        next_cycle();
        rst = 1'b0;
        expect_cycle(rec_off(1'b0));
        for (int i = 1; i < INIT_CYC; i++) begin
            next_cycle();
            expect_cycle(rec_off(1'b0));
        end
        next_cycle();
        expect_cycle(rec_bus(CFG_CA[47:32], CFG_CA[31:16], 1'b1, 1'b0, 1'b0));
        mid();
        chk("cfg_ca1_hi", bus.dq_out_hi, 16'h6000);
        chk("cfg_ca1_lo", bus.dq_out_lo, 16'h0001);
        next_cycle();
        expect_cycle(rec_bus(CFG_CA[15:0], 16'h0000, 1'b1, 1'b0, 1'b0));
        next_cycle();
        expect_cycle(rec_bus(model_cr0(), 16'h0000, 1'b1, 1'b0, 1'b0));
        mid();
        chk("cfg_cr0", bus.dq_out_hi, 16'h8F2D);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            expect_cycle(rec_off(1'b0));
        end
        model_init = 1'b1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        bus.ram_en = 1'b0;
        expect_cycle(rec_off(1'b1));
    endtask

    // One request from its IDLE cycle through RECOVER; abort_at>=0 stops mid-WRITE
    task automatic burst(input logic wr, input logic [31:0] addr, input logic [31:0] d0,
                         input logic hold, input int abort_at, input logic stuck,
                         input logic [15:0] lit_ca1_hi, input logic [15:0] lit_ca2_hi);
        logic [47:0] ca;
        logic [31:0] d;
        logic [1:0]  gap_hi [4];
        logic [1:0]  gap_lo [4];
        gap_hi[0] = 2'b00; gap_lo[0] = 2'b00;
        gap_hi[1] = 2'b11; gap_lo[1] = 2'b11;
        gap_hi[2] = 2'b10; gap_lo[2] = 2'b00;
        gap_hi[3] = 2'b11; gap_lo[3] = 2'b01;
        ca = model_ca(addr, !wr);
        next_cycle();
        bus.ram_en = 1'b1;
        bus.rw_ctrl = wr;
        bus.addr_in = addr;
        expect_cycle(rec_off(1'b1));
        next_cycle();
        if (hold) begin
            bus.rw_ctrl = !wr;
            bus.addr_in = 32'hFFFF_FFFE;
        end else begin
            bus.ram_en = 1'b0;
        end
        expect_cycle(rec_bus(ca[47:32], ca[31:16], 1'b1, 1'b0, 1'b0));
        mid();
        chk("ca1_hi", bus.dq_out_hi, lit_ca1_hi);
        next_cycle();
        expect_cycle(rec_bus(ca[15:0], 16'h0000, 1'b1, 1'b0, 1'b0));
        mid();
        chk("ca2_hi", bus.dq_out_hi, lit_ca2_hi);
        for (int i = 0; i < 2 * LATENCY; i++) begin
            next_cycle();
            expect_cycle(rec_bus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        end
        if (wr) begin
            d = d0;
            for (int i = 0; i < BURST_LEN; i++) begin
                if (i == abort_at) return;
                next_cycle();
                bus.ram_data_in = d;
                expect_cycle(rec_bus(d[31:16], d[15:0], 1'b1, 1'b1, 1'b1));
                mem[i] = d;
                if (d0 == 32'h04060103 && i < 2) begin
                    mid();
                    chk("wr_word_hi", bus.dq_out_hi, (i == 0) ? 16'h0406 : 16'h0507);
                    chk("wr_word_lo", bus.dq_out_lo, (i == 0) ? 16'h0103 : 16'h0204);
                end
                d = d + 32'h0101_0101;
            end
        end else if (stuck) begin
            for (int i = 0; i < 64; i++) begin
                next_cycle();
                bus.dm_in_hi = 2'b00;
                bus.dm_in_lo = 2'b00;
                bus.dq_in_hi = 16'h1234;
                bus.dq_in_lo = 16'h5678;
                expect_cycle(rec_bus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
            end
        end else begin
            for (int i = 0; i < BURST_LEN; i++) begin
                for (int g = 0; g < i % 3; g++) begin
                    next_cycle();
                    bus.dm_in_hi = gap_hi[(i + g) % 4];
                    bus.dm_in_lo = gap_lo[(i + g) % 4];
                    bus.dq_in_hi = 16'hDEAD;
                    bus.dq_in_lo = 16'hBEEF;
                    expect_cycle(rec_bus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
                end
                next_cycle();
                bus.dm_in_hi = 2'b11;
                bus.dm_in_lo = 2'b00;
                bus.dq_in_hi = mem[i][31:16];
                bus.dq_in_lo = mem[i][15:0];
                expect_cycle(rec_bus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
                pend_rd = 1'b1;
                pend_data = mem[i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus.dm_in_hi = 2'b00;
            bus.dm_in_lo = 2'b00;
            expect_cycle(rec_off(1'b0));
        end
    endtask

    initial begin
        bus.ram_en = 1'b0;
        bus.rw_ctrl = 1'b0;
        bus.addr_in = '0;
        bus.ram_data_in = '0;
        bus.dq_in_hi = '0;
        bus.dq_in_lo = '0;
        bus.dm_in_hi = '0;
        bus.dm_in_lo = '0;
        for (int i = 0; i < BURST_LEN; i++) mem[i] = '0;

        apply_reset(3);
        mid();
        chk("reset_ce", bus.psram_ce, 1'b1);
        chk("reset_idle", bus.ctrl_idle, 1'b0);
        init_seq();
        idle_cycle();
        mid();
        chk("init_complete", bus.init_cable_complete, 1'b1);
        chk("idle_after_init", bus.ctrl_idle, 1'b1);

        burst(1'b1, 32'd4, 32'h0406_0103, 1'b0, -1, 1'b0, 16'h2000, 16'h0002);
        idle_cycle();
        burst(1'b0, 32'd4, 32'd0, 1'b0, -1, 1'b0, 16'hA000, 16'h0002);
        mid();
        chk("ce_after_read", bus.psram_ce, 1'b1);
        idle_cycle();

        // ram_en held high across two back-to-back bursts
        burst(1'b1, 32'h0123_4566, 32'h1020_3040, 1'b1, -1, 1'b0, 16'h2012, 16'h0003);
        burst(1'b0, 32'h0123_4566, 32'd0, 1'b1, -1, 1'b0, 16'hA012, 16'h0003);
        idle_cycle();

        // reset in the middle of a write burst
        burst(1'b1, 32'd8, 32'hA0B0_C0D0, 1'b0, 5, 1'b0, 16'h2000, 16'h0004);
        apply_reset(1);
        mid();
        chk("midwr_reset_ce", bus.psram_ce, 1'b1);
        chk("midwr_reset_wrv", bus.ram_wr_valid, 1'b0);
        chk("midwr_reset_dq_en", bus.dq_en, 1'b0);
        init_seq();
        idle_cycle();
`ifdef PSRAM_RD_TIMEOUT_EN
        burst(1'b0, 32'd4, 32'd0, 1'b0, -1, 1'b1, 16'hA000, 16'h0002);
        idle_cycle();
`endif
        repeat (3) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
